// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared types and constants for the instruction fetch buffer.
package fetch_buffer_pkg;
  localparam logic [31:0] nop_instr = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_type;
  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        out_ready;
  } fetch_buffer_in_type;
  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
  } fetch_buffer_out_type;
  function automatic logic is_full_len(input logic [1:0] lo);
    return lo == 2'b11;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetched words; pointers carry an extra wrap bit.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  fetch_entry_type           entry_i,
  input  logic                      pop_i,
  output fetch_entry_type           head_o,
  output logic [31:0]               next_data_o,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_type mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [AW-1:0] nxt_idx;
  logic full, do_push, do_pop;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign do_pop = pop_i && count_o != '0;
  assign do_push = push_i && (!full || do_pop);
  assign nxt_idx = rd_q[AW-1:0] + AW'(1);
  assign head_o = mem_q[rd_q[AW-1:0]];
  assign next_data_o = mem_q[nxt_idx].data;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= entry_i;
  end
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: sequential word fetcher, word FIFO and instruction aligner.
// Define FETCH_BUFFER_COMPRESSED_EN to decode 16-bit instructions at halfword granularity.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_buffer_in_type  fb_in;
  fetch_buffer_out_type fb_out;
  fetch_entry_type head, push_entry;
  logic [31:0] next_data, pc_q, pc_d, fetch_q, fetch_d, redir_pc, instr;
  logic [CW-1:0] count;
  logic outstanding_q, outstanding_d, discard_q, discard_d;
  logic push, pop, accept, word_ok, have_all, is32, ends_word, unused_bits;
  assign fb_in = '{mem_ready, mem_rdata, redirect_valid, redirect_addr, out_ready};
  assign {mem_valid, mem_addr, out_valid, out_pc, out_instr} = fb_out;
`ifdef FETCH_BUFFER_COMPRESSED_EN
  logic [15:0] lo;
  assign lo = pc_q[1] ? head.data[31:16] : head.data[15:0];
  assign is32 = is_full_len(lo[1:0]);
  assign instr = !is32 ? {16'h0, lo} : pc_q[1] ? {next_data[15:0], lo} : head.data;
  // an upper-half 32-bit instruction also needs the following word
  assign have_all = (is32 && pc_q[1]) ? count > CW'(1) : count != '0;
  assign ends_word = pc_q[1] || is32;
  assign redir_pc = {fb_in.redirect_addr[31:1], 1'b0};
`else
  assign is32 = 1'b1;
  assign instr = head.data;
  assign have_all = count != '0;
  assign ends_word = 1'b1;
  assign redir_pc = {fb_in.redirect_addr[31:2], 2'b00};
`endif
  assign unused_bits = ^{head.addr[1:0], next_data, fb_in.redirect_addr[1:0]};
  assign word_ok = head.addr[31:2] == pc_q[31:2];
  assign fb_out.out_valid = !rst && !fb_in.redirect_valid && have_all && word_ok;
  assign fb_out.out_pc = rst ? RESET_PC : pc_q;
  assign fb_out.out_instr = rst ? 32'h0 : instr;
  assign fb_out.mem_valid = !rst && !outstanding_q && !fb_in.redirect_valid && count < CW'(DEPTH);
  assign fb_out.mem_addr = fetch_q;
  assign accept = fb_out.out_valid && fb_in.out_ready;
  assign pop = accept && ends_word;
  // a response belongs to the word just behind the fetch address
  assign push = fb_in.mem_ready && !discard_q && !fb_in.redirect_valid;
  assign push_entry = '{addr: fetch_q - 32'd4, data: fb_in.mem_rdata};
  assign pc_d = fb_in.redirect_valid ? redir_pc : accept ? pc_q + (is32 ? 32'd4 : 32'd2) : pc_q;
  assign fetch_d = fb_in.redirect_valid ? {fb_in.redirect_addr[31:2], 2'b00}
                 : fb_out.mem_valid ? fetch_q + 32'd4 : fetch_q;
  assign outstanding_d = fb_out.mem_valid || (outstanding_q && !fb_in.mem_ready);
  assign discard_d = fb_in.redirect_valid ? outstanding_q && !fb_in.mem_ready
                   : discard_q && !fb_in.mem_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      fetch_q <= {RESET_PC[31:2], 2'b00};
      outstanding_q <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      fetch_q <= fetch_d;
      outstanding_q <= outstanding_d;
      discard_q <= discard_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush_i(fb_in.redirect_valid),
    .push_i(push),
    .entry_i(push_entry),
    .pop_i(pop),
    .head_o(head),
    .next_data_o(next_data),
    .count_o(count)
  );
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: random memory latency, stalls and redirects checked against an instruction-stream model.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
`ifdef FETCH_BUFFER_COMPRESSED_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif
  localparam logic [31:0] PC_MASK = COMP ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_valid, mem_ready = 1'b0, redirect_valid = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] mem_addr, mem_rdata = '0, redirect_addr = '0, out_pc, out_instr;
  int vectors = 0, miscompares = 0;
  logic [31:0] img [256];
  int pend = 0, lat_min = 1, lat_max = 1, reqs = 0, accepts = 0;
  logic [31:0] pend_addr = '0, exp_pc = '0, exp_fetch = '0, delivered_end = '0;
  logic first = 1'b0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w = img[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    logic [15:0] lo = hw(a);
    if (!COMP) return img[a[9:2]];
    return lo[1:0] == 2'b11 ? {hw(a + 32'd2), lo} : {16'h0, lo};
  endfunction

  function automatic logic [31:0] ilen(input logic [31:0] ins);
    return (!COMP || ins[1:0] == 2'b11) ? 32'd4 : 32'd2;
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b0; redirect_valid = 1'b0; out_ready = 1'($urandom_range(1, 0)); pend = 0;
      #1;
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", out_pc, 32'h0);
    end
    exp_pc = 32'h0; exp_fetch = 32'h0; delivered_end = 32'h0; first = 1'b1;
  endtask

  task automatic cycle(input logic redir, input logic [31:0] raddr, input logic rdy);
    logic busy;
    logic [31:0] ei, len;
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = redir; redirect_addr = raddr; out_ready = rdy; mem_ready = 1'b0;
    if (pend == 1) begin
      mem_ready = 1'b1;
      mem_rdata = img[pend_addr[9:2]];
      if (pend_addr == delivered_end) delivered_end += 32'd4;
    end
    pend = pend > 0 ? pend - 1 : 0;
    #1;
    busy = pend != 0 || mem_ready;
    if (first) begin
      chk("first_req", 32'(mem_valid), 32'd1);
      first = 1'b0;
    end
    if (redir) chk("redir_out_valid", 32'(out_valid), 32'd0);
    if (mem_valid) begin
      chk("one_outstanding", 32'(busy), 32'd0);
      chk("req_addr", mem_addr, exp_fetch);
      exp_fetch += 32'd4;
      reqs++;
      pend = $urandom_range(lat_max, lat_min);
      pend_addr = mem_addr;
    end
    if (out_valid) begin
      ei = instr_at(exp_pc);
      len = ilen(ei);
      chk("complete", 32'(exp_pc + len <= delivered_end), 32'd1);
      if (rdy) begin
        chk("out_pc", out_pc, exp_pc);
        chk("out_instr", out_instr, ei);
        exp_pc += len;
        accepts++;
      end
    end
    if (redir) begin
      exp_fetch = raddr & 32'hFFFF_FFFC;
      exp_pc = raddr & PC_MASK;
      delivered_end = exp_fetch;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = $urandom | 32'h0003_0003;
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    do_reset(3);
    lat_min = 1; lat_max = 1; accepts = 0;
    repeat (8) cycle(1'b0, 32'h0, 1'b1);
    chk("seq_accepts", 32'(accepts >= 2), 32'd1);
    if (COMP) begin
      img[0] = 32'h0013_4505;
      img[1] = 32'h0001_0000;
      do_reset(2);
      lat_min = 3; lat_max = 3; accepts = 0;
      repeat (14) cycle(1'b0, 32'h0, 1'b1);
      chk("rvc_accepts", 32'(accepts >= 3), 32'd1);
    end
    do_reset(2);
    lat_min = 1; lat_max = 3; reqs = 0; accepts = 0;
    repeat (20) cycle(1'b0, 32'h0, 1'b0);
    chk("full_reqs", reqs, DEPTH);
    repeat (12) cycle(1'b0, 32'h0, 1'b1);
    chk("drain", 32'(accepts >= DEPTH), 32'd1);
    do_reset(2);
    lat_min = 3; lat_max = 3; accepts = 0;
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h100, 1'b1);
    repeat (12) cycle(1'b0, 32'h0, 1'b1);
    chk("redir_progress", 32'(accepts > 0), 32'd1);
    do_reset(2);
    lat_min = 2; lat_max = 2;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("coincide_next_req", 32'(mem_valid), 32'd1);
    chk("coincide_addr", mem_addr, 32'h40);
    for (int i = 0; i < 256; i++) img[i] = COMP ? $urandom : ($urandom | 32'h3);
    do_reset(2);
    accepts = 0;
    for (int s = 0; s < 8; s++) begin
      int stall, rpct;
      lat_min = $urandom_range(2, 1);
      lat_max = lat_min + $urandom_range(3, 0);
      stall = $urandom_range(60, 0);
      rpct = $urandom_range(5, 0);
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(999, 0) < 3) do_reset($urandom_range(3, 1));
        cycle($urandom_range(99, 0) < rpct, $urandom_range(1023, 0), $urandom_range(99, 0) >= stall);
      end
    end
    chk("progress", 32'(accepts > 200), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
